disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexes NDIG hex digits onto one shared MC14495_ZJU hex-to-7-segment decoder.
- Drives the decoder inputs D[3:0], point and LE, plus the active-low digit-select lines AN.
- Adds per-digit blanking and blinking.
- Host writes use a load strobe and are applied only at frame boundaries, so a displayed frame never mixes old and new data.

Parameters:
- NDIG, 4: number of multiplexed digits; range 2..8.
- SCAN_DIV, 100000: clk cycles each digit is shown; minimum 2.
- BLINK_FRAMES, 64: full frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- hexs  in  4*NDIG  digit codes; digit k is hexs[4k+3:4k].
- points  in  NDIG  decimal point per digit, active-high.
- les  in  NDIG  per-digit blank, 1 = blank.
- blink  in  NDIG  per-digit blink enable.
- load  in  1  single-cycle strobe; captures hexs/points/les/blink.
- pending  out  1  high while captured data waits for the frame boundary.
- D  out  4  code for the shared decoder.
- point  out  1  point for the shared decoder.
- LE  out  1  decoder blank, 1 = segments off.
- AN  out  NDIG  digit select, active-low, one-cold.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset, synchronous, active-high, taking effect on the next clk edge while rst=1:
  - prescaler=0, idx=0, blink_cnt=0, blink_phase=0, pending=0.
  - Active registers: hex=0, points=0, les=all-1, blink=0.
  - Outputs: D=0, point=0, LE=1, AN=~1 (4'b1110 for NDIG=4), frame_done=0.
  - rst during a scan abandons the frame and drops any pending data.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick=1 when prescaler==SCAN_DIV-1.
- Digit index: on tick, idx increments; NDIG-1 wraps to 0.
- frame_done=1 in the cycle where tick=1 and idx==NDIG-1 (the "boundary" cycle).
- Outputs are combinational from registered state, with no extra latency:
  - D = active hex[idx]; point = active points[idx].
  - LE = les[idx] | (blink[idx] & blink_phase).
  - AN = ~(1<<idx), so AN changes on the edge after tick.
- Blink: blink_cnt counts boundaries 0..BLINK_FRAMES-1. At wrap it returns to 0 and blink_phase toggles.
- Load/shadow handling:
  - load=1 captures inputs into the shadow register and sets pending=1. A later load before the boundary overwrites the shadow (last wins).
  - At a boundary with pending=1, shadow is copied to active and pending clears.
  - load in the boundary cycle itself: that cycle's inputs go straight to active, and pending stays/becomes 0.
  - New data is therefore first visible when idx=0 of the next frame. Worst-case latency is NDIG*SCAN_DIV cycles.
- Partial frames are never shown: active data changes only at boundaries.
- blink/les changes obey the same shadowing rule as hexs.

Decomposition:
- Package disp_pkg holds:
  - IDX_W = clog2(NDIG) function/constant.
  - an_decode function: idx to one-cold AN.
  - A struct/typedef bundling hex/points/les/blink for the shadow and active registers.
- One sub-module, scan_prescaler: parameterised by SCAN_DIV; outputs tick; synchronous rst.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2, NDIG=4):
- Reset: hold rst 2 cycles → LE=1, AN=4'b1110, D=0, pending=0. After release, AN walks 1110→1101→1011→0111→1110 every 4 cycles; frame_done pulses once every 16 cycles.
- Load mid-frame: load with hexs=16'h3A5C, les=0 while idx=1 → pending=1 until the boundary, then clears. At idx=0,1,2,3, D=C,5,A,3 and LE=0; old data is shown for the rest of the current frame.
- Double load: load 16'h1111, then 16'h2222 two cycles later, same frame → the next frame shows only 2s; 1s never appear.
- Boundary load: load 16'hBEEF exactly in the frame_done cycle → pending stays 0; the next cycle (idx=0) shows D=F.
- Blink: blink=4'b0100, les=0 → digit 2 has LE=0 for 2 frames, then LE=1 for 2 frames, repeating; other digits keep LE=0 throughout.
- Reset mid-operation: assert rst at idx=2 with pending=1 → next cycle idx=0, pending=0, LE=1, and the shadowed data is never displayed.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Holds the display register bundle, the index width helper and the
// one-cold digit-select decoder.
package disp_pkg;

    localparam int unsigned MAX_DIG   = 8;
    localparam int unsigned MAX_IDX_W = 3;
    localparam int unsigned HEX_W     = MAX_DIG * 4;

    // One bank of display data (used for both shadow and active copies).
    // Sized for the largest supported digit count; unused digits stay zero.
    typedef struct packed {
        logic [MAX_DIG-1:0][3:0] hex;
        logic [MAX_DIG-1:0]      points;
        logic [MAX_DIG-1:0]      les;
        logic [MAX_DIG-1:0]      blink;
    } disp_regs_t;

    // Digit index width; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

    // Active-low one-cold digit select for the given index.
    function automatic logic [MAX_DIG-1:0] an_decode(input logic [MAX_IDX_W-1:0] idx);
        return ~(MAX_DIG'(1) << idx);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host and decoder-side signal bundle of disp_scan_ctrl.
//   master: drives hexs/points/les/blink/load, observes pending and decoder lines
//   slave : the controller; drives pending, D, point, LE, AN, frame_done
interface disp_scan_ctrl_if #(
    parameter int unsigned NDIG = 4
);
    logic [4*NDIG-1:0] hexs;
    logic [NDIG-1:0]   points;
    logic [NDIG-1:0]   les;
    logic [NDIG-1:0]   blink;
    logic              load;
    logic              pending;
    logic [3:0]        D;
    logic              point;
    logic              LE;
    logic [NDIG-1:0]   AN;
    logic              frame_done;

    modport master (
        output hexs, points, les, blink, load,
        input  pending, D, point, LE, AN, frame_done
    );

    modport slave (
        input  hexs, points, les, blink, load,
        output pending, D, point, LE, AN, frame_done
    );
endinterface

// File: rtl/scan_prescaler.sv
// Free-running divider that marks the last cycle of each digit slot.
//   clk, rst  : clock and synchronous active-high reset
//   tick_c_o  : high while the counter sits at SCAN_DIV-1
module scan_prescaler #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_c_o
);
    localparam int unsigned    CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count 0..SCAN_DIV-1 and wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    assign tick_c_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexes NDIG hex digits onto one shared hex-to-7-segment decoder,
// with per-digit blanking/blinking and frame-aligned host updates.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of disp_scan_ctrl_if (host inputs, decoder outputs)
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NDIG         = 4,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic             clk,
    input  logic             rst,
    disp_scan_ctrl_if.slave  bus
);
    localparam int unsigned      IDX_W      = idx_w(NDIG);
    localparam int unsigned      BC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NDIG - 1);
    localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_FRAMES - 1);
    localparam disp_regs_t       RST_REGS   = '{hex: '0, points: '0, les: '1, blink: '0};

    logic                 tick_c;
    logic                 boundary_c;
    logic [MAX_IDX_W-1:0] idx_ext_c;
    disp_regs_t           in_c;

    logic [IDX_W-1:0] idx_q,         idx_d;
    logic [BC_W-1:0]  blink_cnt_q,   blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic             pending_q,     pending_d;
    disp_regs_t       shadow_q,      shadow_d;
    disp_regs_t       active_q,      active_d;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .tick_c_o (tick_c)
    );

    // Last cycle of the last digit slot: the only point active data may change.
    assign boundary_c = tick_c && (idx_q == LAST_IDX);
    assign idx_ext_c  = MAX_IDX_W'(idx_q);

    // Host inputs widened into the register bundle.
    always_comb begin
        in_c        = '0;
        in_c.hex    = HEX_W'(bus.hexs);
        in_c.points = MAX_DIG'(bus.points);
        in_c.les    = MAX_DIG'(bus.les);
        in_c.blink  = MAX_DIG'(bus.blink);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= RST_REGS;
            active_q      <= RST_REGS;
        end else begin
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    // Next-state: digit walk, blink timing and shadow/active handover.
    always_comb begin
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        active_d      = active_q;

        if (tick_c) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        if (boundary_c) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BC_W'(1);
            end

            // A load in the boundary cycle bypasses the shadow entirely.
            if (bus.load) begin
                active_d = in_c;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            shadow_d  = in_c;
            pending_d = 1'b1;
        end
    end

    // Decoder drive straight from registered state.
    assign bus.D          = active_q.hex[idx_ext_c];
    assign bus.point      = active_q.points[idx_ext_c];
    assign bus.LE         = active_q.les[idx_ext_c] | (active_q.blink[idx_ext_c] & blink_phase_q);
    assign bus.AN         = NDIG'(an_decode(idx_ext_c));
    assign bus.frame_done = boundary_c;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (NDIG=4, SCAN_DIV=4, BLINK_FRAMES=2).
// A frame-level model predicts every output each cycle; literal checks pin it.
module tb_disp_scan_ctrl;
    localparam int NDIG         = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int FR           = NDIG * SCAN_DIV;

    typedef struct {
        int          lt;
        logic [15:0] hex;
        logic [3:0]  pts;
        logic [3:0]  les;
        logic [3:0]  blk;
    } load_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    disp_scan_ctrl_if #(.NDIG(NDIG)) bus ();

    disp_scan_ctrl #(
        .NDIG         (NDIG),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: cycles since reset plus the history of accepted loads.
    load_t hist[$];
    int    m_t;
    bit    m_valid;

    initial begin
        m_t     = 0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            m_t     <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (bus.load) hist.push_back('{m_t, bus.hexs, bus.points, bus.les, bus.blink});
            m_t <= m_t + 1;
        end
    end

    // A frame shows the newest load made before it started; pending means
    // some load already happened inside the current frame.
    int          f, ix;
    logic [15:0] e_hex;
    logic [3:0]  e_pts, e_les, e_blk;
    logic        e_pend, e_phase;
    always @(negedge clk) begin
        if (m_valid) begin
            f      = m_t / FR;
            ix     = (m_t / SCAN_DIV) % NDIG;
            e_hex  = 16'h0;
            e_pts  = 4'h0;
            e_les  = 4'hF;
            e_blk  = 4'h0;
            e_pend = 1'b0;
            foreach (hist[i]) begin
                if (hist[i].lt < f * FR) begin
                    e_hex = hist[i].hex;
                    e_pts = hist[i].pts;
                    e_les = hist[i].les;
                    e_blk = hist[i].blk;
                end
                if (hist[i].lt / FR == f) e_pend = 1'b1;
            end
            e_phase = ((f / BLINK_FRAMES) % 2) == 1;
            check($sformatf("model D t=%0d", m_t), 32'(bus.D), 32'(4'(e_hex >> (4 * ix))));
            check($sformatf("model point t=%0d", m_t), 32'(bus.point), 32'(e_pts[ix]));
            check($sformatf("model LE t=%0d", m_t), 32'(bus.LE), 32'(e_les[ix] | (e_blk[ix] & e_phase)));
            check($sformatf("model AN t=%0d", m_t), 32'(bus.AN), 32'(4'(~(32'd1 << ix))));
            check($sformatf("model pending t=%0d", m_t), 32'(bus.pending), 32'(e_pend));
            check($sformatf("model frame_done t=%0d", m_t), 32'(bus.frame_done),
                  32'((m_t % FR) == FR - 1));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l,
                           input logic [3:0] b);
        bus.hexs   = h;
        bus.points = p;
        bus.les    = l;
        bus.blink  = b;
        bus.load   = 1'b1;
        step(1);
        bus.load   = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        bus.hexs   = '0;
        bus.points = '0;
        bus.les    = '0;
        bus.blink  = '0;
        bus.load   = 1'b0;

        // Reset state
        step(2);
        check("rst LE", 32'(bus.LE), 32'd1);
        check("rst AN", 32'(bus.AN), 32'hE);
        check("rst D", 32'(bus.D), 32'd0);
        check("rst pending", 32'(bus.pending), 32'd0);
        rst = 1'b0;

        // Digit walk, t counts edges since reset
        step(4);  check("walk AN t4", 32'(bus.AN), 32'hD);
        step(4);  check("walk AN t8", 32'(bus.AN), 32'hB);
        step(4);  check("walk AN t12", 32'(bus.AN), 32'h7);
        step(3);  check("frame_done t15", 32'(bus.frame_done), 32'd1);
        step(1);  check("walk AN t16", 32'(bus.AN), 32'hE);
        check("frame_done t16", 32'(bus.frame_done), 32'd0);

        // Mid-frame load at idx=1
        step(5);
        do_load(16'h3A5C, 4'b1010, 4'h0, 4'h0);
        check("mid pending t22", 32'(bus.pending), 32'd1);
        step(9);
        check("mid pending t31", 32'(bus.pending), 32'd1);
        check("mid old D t31", 32'(bus.D), 32'd0);
        step(1);
        check("mid pending t32", 32'(bus.pending), 32'd0);
        check("mid D idx0", 32'(bus.D), 32'hC);
        check("mid LE idx0", 32'(bus.LE), 32'd0);
        step(4);  check("mid D idx1", 32'(bus.D), 32'h5);
        check("mid point idx1", 32'(bus.point), 32'd1);
        step(4);  check("mid D idx2", 32'(bus.D), 32'hA);
        step(4);  check("mid D idx3", 32'(bus.D), 32'h3);

        // Double load in one frame: last wins
        step(4);
        do_load(16'h1111, 4'h0, 4'h0, 4'h0);
        step(1);
        do_load(16'h2222, 4'h0, 4'h0, 4'h0);
        step(13); check("dbl D idx0", 32'(bus.D), 32'h2);
        step(12); check("dbl D idx3", 32'(bus.D), 32'h2);

        // Load in the boundary cycle goes straight to active
        step(3);
        check("bnd frame_done", 32'(bus.frame_done), 32'd1);
        do_load(16'hBEEF, 4'b0001, 4'h0, 4'h0);
        check("bnd pending", 32'(bus.pending), 32'd0);
        check("bnd D", 32'(bus.D), 32'hF);
        check("bnd point", 32'(bus.point), 32'd1);

        // Blink on digit 2
        do_load(16'hBEEF, 4'h0, 4'h0, 4'b0100);
        step(23);
        check("blink D idx2 f6", 32'(bus.D), 32'hE);
        check("blink LE idx2 f6", 32'(bus.LE), 32'd1);
        step(32);
        check("blink LE idx2 f8", 32'(bus.LE), 32'd0);

        // Reset while data is pending
        step(8);
        do_load(16'h7777, 4'h0, 4'h0, 4'h0);
        step(7);
        check("rmid pending", 32'(bus.pending), 32'd1);
        check("rmid AN idx2", 32'(bus.AN), 32'hB);
        rst = 1'b1;
        step(1);
        check("rmid AN", 32'(bus.AN), 32'hE);
        check("rmid pending clr", 32'(bus.pending), 32'd0);
        check("rmid LE", 32'(bus.LE), 32'd1);
        rst = 1'b0;
        step(16);
        check("rmid D later", 32'(bus.D), 32'd0);
        check("rmid LE later", 32'(bus.LE), 32'd1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
